// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Owns the PC, fetches over a req/gnt/rvalid handshake and holds one instruction for the controller.
module pc_fetch_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = {XLEN{1'b0}},
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned      INSTR_BYTES  = 4,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             pc_clk,
  input  logic             reset,
  input  logic             pc_update,
  input  logic [1:0]       pc_src,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  target,
  input  logic             flush_valid,
  input  logic [XLEN-1:0]  flush_target,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             instr_valid,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [XLEN-1:0]  STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0]  BIT0_CLR   = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_r;
  logic [XLEN-1:0]   pc_r;
  logic              imem_req_r;
  logic              instr_valid_r;
  logic [XLEN-1:0]   instr_r;
  logic [XLEN-1:0]   instr_pc_r;
  logic              misalign_exc_r;
  logic [XLEN-1:0]   epc_r;
  logic [CNT_W-1:0]  instret_r;
  logic [XLEN-1:0]   npc_s;
  logic              npc_misaligned_s;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & ALIGN_MASK) != {XLEN{1'b0}};
  endfunction

  // Arithmetic wraps modulo 2^XLEN by construction.
  function automatic logic [XLEN-1:0] next_pc(
    input logic [1:0]      src,
    input logic [XLEN-1:0] base,
    input logic [XLEN-1:0] offs,
    input logic [XLEN-1:0] abs_tgt
  );
    logic [XLEN-1:0] res;
    case (src)
      2'b00:   res = base + STEP;
      2'b01:   res = base + offs;
      2'b10:   res = abs_tgt & BIT0_CLR;
      2'b11:   res = TRAP_VECTOR;
      default: res = TRAP_VECTOR;
    endcase
    return res;
  endfunction

  // Candidate next PC relative to the held instruction, plus its alignment check.
  always_comb begin
    npc_s            = next_pc(pc_src, instr_pc_r, imm, target);
    npc_misaligned_s = is_misaligned(npc_s);
  end

  // Fetch FSM; flush has priority over every other event once out of IDLE.
  always_ff @(posedge pc_clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      pc_r           <= RESET_VECTOR;
      imem_req_r     <= 1'b0;
      instr_valid_r  <= 1'b0;
      instr_r        <= {XLEN{1'b0}};
      instr_pc_r     <= {XLEN{1'b0}};
      misalign_exc_r <= 1'b0;
      epc_r          <= {XLEN{1'b0}};
      instret_r      <= {CNT_W{1'b0}};
    end else begin
      misalign_exc_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_REQ;
          imem_req_r <= 1'b1;
        end
        ST_REQ: begin
          if (flush_valid) begin
            pc_r          <= flush_target;
            instr_valid_r <= 1'b0;
            // A granted request still owes us a response, so it must be drained.
            if (imem_gnt) begin
              state_r    <= ST_DRAIN;
              imem_req_r <= 1'b0;
            end else begin
              state_r    <= ST_REQ;
              imem_req_r <= 1'b1;
            end
          end else if (imem_gnt) begin
            state_r    <= ST_WAIT;
            imem_req_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (flush_valid) begin
            pc_r          <= flush_target;
            instr_valid_r <= 1'b0;
            if (imem_rvalid) begin
              state_r    <= ST_REQ;
              imem_req_r <= 1'b1;
            end else begin
              state_r    <= ST_DRAIN;
              imem_req_r <= 1'b0;
            end
          end else if (imem_rvalid) begin
            instr_r       <= imem_rdata;
            instr_pc_r    <= pc_r;
            instr_valid_r <= 1'b1;
            state_r       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (flush_valid) begin
            pc_r          <= flush_target;
            instr_valid_r <= 1'b0;
            state_r       <= ST_REQ;
            imem_req_r    <= 1'b1;
          end else if (pc_update) begin
            instret_r     <= instret_r + CNT_ONE;
            instr_valid_r <= 1'b0;
            state_r       <= ST_REQ;
            imem_req_r    <= 1'b1;
            if (npc_misaligned_s) begin
              pc_r           <= TRAP_VECTOR;
              epc_r          <= npc_s;
              misalign_exc_r <= 1'b1;
            end else begin
              pc_r <= npc_s;
            end
          end
        end
        ST_DRAIN: begin
          if (flush_valid) begin
            pc_r          <= flush_target;
            instr_valid_r <= 1'b0;
          end else if (imem_rvalid) begin
            state_r    <= ST_REQ;
            imem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_r;
  assign imem_addr    = pc_r;
  assign instr_valid  = instr_valid_r;
  assign instr        = instr_r;
  assign instr_pc     = instr_pc_r;
  assign misalign_exc = misalign_exc_r;
  assign epc          = epc_r;
  assign instret      = instret_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit: cycle table plus hand sequences for flush/reset corners.
module tb_pc_fetch_unit;

  logic        pc_clk = 1'b0;
  logic        reset;
  logic        pc_update;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] target;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_exc;
  logic [31:0] epc;
  logic [31:0] instret;

  int applied = 0;
  int miscompares = 0;

  pc_fetch_unit dut (
    .pc_clk(pc_clk), .reset(reset), .pc_update(pc_update), .pc_src(pc_src),
    .imm(imm), .target(target), .flush_valid(flush_valid), .flush_target(flush_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .misalign_exc(misalign_exc), .epc(epc),
    .instret(instret)
  );

  always #5 pc_clk = ~pc_clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        upd;
    logic [1:0]  src;
    logic        fl;
    logic [31:0] op;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_exc;
    logic [31:0] e_epc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic rst, input logic upd,
                              input logic [1:0] src, input logic fl, input logic [31:0] op,
                              input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_instr, input logic [31:0] e_ipc,
                              input logic e_exc, input logic [31:0] e_epc,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.name = nm; v.rst = rst; v.upd = upd; v.src = src; v.fl = fl; v.op = op;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_exc = e_exc;
    v.e_epc = e_epc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_ivalid(input string nm, input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    applied++;
    if (instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: instr_valid not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // name, rst,upd,src,fl,op, gnt,rv,rdata | req,addr,iv,instr,ipc,exc,epc,cnt
    add("reset",       0,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h0,0,32'h0,32'h0,0,32'h0,32'd0);
    add("idle_to_req", 1,0,2'd0,0,32'h0,        1,1,32'h13,   1,32'h0,0,32'h0,32'h0,0,32'h0,32'd0);
    add("gnt_wait",    1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h0,0,32'h0,32'h0,0,32'h0,32'd0);
    add("first_hold",  1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h0,1,32'h13,32'h0,0,32'h0,32'd0);
    add("seq1",        1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h4,0,32'h13,32'h0,0,32'h0,32'd1);
    add("upd_in_req",  1,1,2'd3,0,32'h0,        1,1,32'h13,   0,32'h4,0,32'h13,32'h0,0,32'h0,32'd1);
    add("hold4",       1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h4,1,32'h13,32'h4,0,32'h0,32'd1);
    add("seq2",        1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h8,0,32'h13,32'h4,0,32'h0,32'd2);
    add("wait8",       1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h8,0,32'h13,32'h4,0,32'h0,32'd2);
    add("hold8",       1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h8,1,32'h13,32'h8,0,32'h0,32'd2);
    add("seq3",        1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'hC,0,32'h13,32'h8,0,32'h0,32'd3);
    add("waitC",       1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'hC,0,32'h13,32'h8,0,32'h0,32'd3);
    add("holdC",       1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'hC,1,32'h13,32'hC,0,32'h0,32'd3);
    add("flush_hold",  1,0,2'd0,1,32'h40,       1,1,32'h13,   1,32'h40,0,32'h13,32'hC,0,32'h0,32'd3);
    add("wait40",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h40,0,32'h13,32'hC,0,32'h0,32'd3);
    add("hold40",      1,0,2'd0,0,32'h0,        1,1,32'hA00093, 0,32'h40,1,32'hA00093,32'h40,0,32'h0,32'd3);
    add("rel_neg",     1,1,2'd1,0,32'hFFFFFFF0, 1,1,32'h13,   1,32'h30,0,32'hA00093,32'h40,0,32'h0,32'd4);
    add("wait30",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h30,0,32'hA00093,32'h40,0,32'h0,32'd4);
    add("hold30",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h30,1,32'h13,32'h30,0,32'h0,32'd4);
    add("abs_bit0",    1,1,2'd2,0,32'h201,      1,1,32'h13,   1,32'h200,0,32'h13,32'h30,0,32'h0,32'd5);
    add("wait200",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h200,0,32'h13,32'h30,0,32'h0,32'd5);
    add("hold200",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h200,1,32'h13,32'h200,0,32'h0,32'd5);
    add("abs_misal",   1,1,2'd2,0,32'h202,      1,1,32'h13,   1,32'h100,0,32'h13,32'h200,1,32'h202,32'd6);
    add("exc_pulse",   1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,0,32'h13,32'h200,0,32'h202,32'd6);
    add("hold100",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,1,32'h13,32'h100,0,32'h202,32'd6);
    add("trap_sel",    1,1,2'd3,0,32'h0,        1,1,32'h13,   1,32'h100,0,32'h13,32'h100,0,32'h202,32'd7);
    add("wait_trap",   1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,0,32'h13,32'h100,0,32'h202,32'd7);
    add("hold_trap",   1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,1,32'h13,32'h100,0,32'h202,32'd7);
    add("flush_top",   1,0,2'd0,1,32'hFFFFFFFC, 1,1,32'h13,   1,32'hFFFFFFFC,0,32'h13,32'h100,0,32'h202,32'd7);
    add("wait_top",    1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'hFFFFFFFC,0,32'h13,32'h100,0,32'h202,32'd7);
    add("hold_top",    1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'hFFFFFFFC,1,32'h13,32'hFFFFFFFC,0,32'h202,32'd7);
    add("seq_wrap",    1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h0,0,32'h13,32'hFFFFFFFC,0,32'h202,32'd8);
    add("wait_wrap",   1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h0,0,32'h13,32'hFFFFFFFC,0,32'h202,32'd8);
    add("hold_wrap",   1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h0,1,32'h13,32'h0,0,32'h202,32'd8);
    add("flush_upd",   1,1,2'd0,1,32'h80,       1,1,32'h13,   1,32'h80,0,32'h13,32'h0,0,32'h202,32'd8);
    add("wait80",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h80,0,32'h13,32'h0,0,32'h202,32'd8);
    add("hold80",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h80,1,32'h13,32'h80,0,32'h202,32'd8);
    add("flush_odd",   1,0,2'd0,1,32'h82,       1,1,32'h13,   1,32'h82,0,32'h13,32'h80,0,32'h202,32'd8);
    add("wait82",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h82,0,32'h13,32'h80,0,32'h202,32'd8);
    add("hold82",      1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h82,1,32'h13,32'h82,0,32'h202,32'd8);
    add("seq_misal",   1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h100,0,32'h13,32'h82,1,32'h86,32'd9);
    add("wait_m2",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,0,32'h13,32'h82,0,32'h86,32'd9);
    add("hold_m2",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h100,1,32'h13,32'h100,0,32'h86,32'd9);
    add("seq104",      1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h104,0,32'h13,32'h100,0,32'h86,32'd10);
    add("req_no_gnt",  1,0,2'd0,0,32'h0,        0,1,32'h13,   1,32'h104,0,32'h13,32'h100,0,32'h86,32'd10);
    add("flush_req",   1,0,2'd0,1,32'h300,      0,1,32'h13,   1,32'h300,0,32'h13,32'h100,0,32'h86,32'd10);
    add("wait300",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h300,0,32'h13,32'h100,0,32'h86,32'd10);
    add("hold300",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h300,1,32'h13,32'h300,0,32'h86,32'd10);
    add("seq304",      1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h304,0,32'h13,32'h300,0,32'h86,32'd11);
    add("flush_gnt",   1,0,2'd0,1,32'h400,      1,0,32'h13,   0,32'h400,0,32'h13,32'h300,0,32'h86,32'd11);
    add("drain_idle",  1,0,2'd0,0,32'h0,        1,0,32'h13,   0,32'h400,0,32'h13,32'h300,0,32'h86,32'd11);
    add("drain_flush", 1,0,2'd0,1,32'h500,      1,0,32'h13,   0,32'h500,0,32'h13,32'h300,0,32'h86,32'd11);
    add("drain_done",  1,0,2'd0,0,32'h0,        1,1,32'hDEAD, 1,32'h500,0,32'h13,32'h300,0,32'h86,32'd11);
    add("rv_in_req",   1,0,2'd0,0,32'h0,        1,1,32'hDEAD, 0,32'h500,0,32'h13,32'h300,0,32'h86,32'd11);
    add("hold500",     1,0,2'd0,0,32'h0,        1,1,32'h33,   0,32'h500,1,32'h33,32'h500,0,32'h86,32'd11);
    add("seq504",      1,1,2'd0,0,32'h0,        1,1,32'h13,   1,32'h504,0,32'h33,32'h500,0,32'h86,32'd12);
    add("wait504",     1,0,2'd0,0,32'h0,        1,0,32'h13,   0,32'h504,0,32'h33,32'h500,0,32'h86,32'd12);
    add("flush_rv",    1,0,2'd0,1,32'h600,      1,1,32'hBAD,  1,32'h600,0,32'h33,32'h500,0,32'h86,32'd12);
    add("wait600",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h600,0,32'h33,32'h500,0,32'h86,32'd12);
    add("hold600",     1,0,2'd0,0,32'h0,        1,1,32'h13,   0,32'h600,1,32'h13,32'h600,0,32'h86,32'd12);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; pc_update = vecs[i].upd; pc_src = vecs[i].src;
      imm = vecs[i].op; target = vecs[i].op; flush_valid = vecs[i].fl;
      flush_target = vecs[i].op; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv;
      imem_rdata = vecs[i].rdata;
      step();
      applied++;
      if (imem_req !== vecs[i].e_req || imem_addr !== vecs[i].e_addr ||
          instr_valid !== vecs[i].e_iv || instr !== vecs[i].e_instr ||
          instr_pc !== vecs[i].e_ipc || misalign_exc !== vecs[i].e_exc ||
          epc !== vecs[i].e_epc || instret !== vecs[i].e_cnt) begin
        miscompares++;
        $display("FAIL %s: got req=%b addr=%h iv=%b instr=%h ipc=%h exc=%b epc=%h cnt=%0d expected req=%b addr=%h iv=%b instr=%h ipc=%h exc=%b epc=%h cnt=%0d",
                 vecs[i].name, imem_req, imem_addr, instr_valid, instr, instr_pc,
                 misalign_exc, epc, instret, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
                 vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_exc, vecs[i].e_epc, vecs[i].e_cnt);
      end
    end

    // Flush in WAIT with a slow response: 0xDEAD must be dropped, 0x80 refetched.
    pc_update = 1'b1; pc_src = 2'd0; flush_valid = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    step();
    chk("slow_req_addr", imem_addr, 32'h604);
    chk("slow_instret", instret, 32'd13);
    pc_update = 1'b0;
    step();
    chk("slow_wait_req", {31'd0, imem_req}, 32'd0);
    flush_valid = 1'b1; flush_target = 32'h80;
    step();
    flush_valid = 1'b0;
    chk("slow_drain_addr", imem_addr, 32'h80);
    chk("slow_drain_iv", {31'd0, instr_valid}, 32'd0);
    step();
    chk("slow_drain_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
    step();
    chk("slow_refetch_req", {31'd0, imem_req}, 32'd1);
    chk("slow_refetch_addr", imem_addr, 32'h80);
    imem_rdata = 32'h93;
    wait_ivalid("slow_refetch_done", 8);
    chk("slow_instr", instr, 32'h93);
    chk("slow_instr_pc", instr_pc, 32'h80);

    // Reset during WAIT; the late response must not surface as an instruction.
    pc_update = 1'b1; imem_rvalid = 1'b0;
    step();
    pc_update = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instr", instr, 32'd0);
    reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBEEF; imem_gnt = 1'b0;
    step();
    chk("rst_late_rv_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_restart_addr", imem_addr, 32'h0);
    step();
    chk("rst_req_held", {31'd0, imem_req}, 32'd1);
    chk("rst_iv_held", {31'd0, instr_valid}, 32'd0);
    imem_gnt = 1'b1; imem_rdata = 32'h13;
    wait_ivalid("rst_refetch_done", 8);
    chk("rst_refetch_instr", instr, 32'h13);
    chk("rst_refetch_pc", instr_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
